// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader.
// Holds the default data/address widths, the packet-counter width and the
// reader FSM state encoding.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 32;
  localparam int unsigned ASIZE_DEF = 4;
  localparam int unsigned PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer between the FIFO pop path and the stream port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (caller guarantees !full)
//   pop             consumer accepts the head entry this cycle
//   head_data       registered head entry
//   head_valid      head entry present
//   full            both entries occupied
module fifo_skid_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  logic [WIDTH-1:0] tail_data;

  // Head/tail registers; the tail only ever holds a word while the head is
  // occupied, so a pop always promotes the tail and keeps order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      tail_data  <= '0;
      full       <= 1'b0;
    end else if (pop && head_valid) begin
      if (full) begin
        head_data <= tail_data;
        if (push) begin
          tail_data <= push_data;
        end else begin
          full <= 1'b0;
        end
      end else if (push) begin
        head_data <= push_data;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_data  <= push_data;
        head_valid <= 1'b1;
      end else begin
        tail_data <= push_data;
        full      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads packets out of a first-word-fall-through FIFO onto a valid/ready
// stream. A packet of PKT_LEN words starts once that many are present; flush_i
// starts a short packet from whatever is present.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   fifo_rd_data_i/fifo_empty_i/fifo_counter_i  upstream FIFO head/status
//   fifo_rd_en_o                           pop strobe to the FIFO
//   flush_i                                emit residual words as a packet
//   m_data_o/m_valid_o/m_last_o/m_ready_i  output stream
//   pkt_count_o                            completed packets (wraps)
//   busy_o                                 FSM not idle
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned ASIZE   = ASIZE_DEF,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DSIZE-1:0]     fifo_rd_data_i,
  input  logic                 fifo_empty_i,
  input  logic [ASIZE:0]       fifo_counter_i,
  output logic                 fifo_rd_en_o,
  input  logic                 flush_i,
  output logic [DSIZE-1:0]     m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic [PKT_CNT_W-1:0] pkt_count_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = ASIZE + 1;
  localparam int unsigned BUF_W = DSIZE + 1;

  if (PKT_LEN < 1 || PKT_LEN > (32'd1 << ASIZE)) begin : g_bad_pkt_len
    $error("fifo_burst_reader: PKT_LEN must be within 1..2**ASIZE");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [PKT_CNT_W-1:0] pkt_count_q;
  logic [BUF_W-1:0]     head;
  logic                 head_valid;
  logic                 buf_full;
  logic                 pop_c;
  logic                 last_done_c;

  // Pop depends only on registered state and FIFO status, never on m_ready_i;
  // reset suppresses it so an in-flight packet is abandoned without popping.
  assign pop_c = (state_q == BURST) && (remaining_q != '0) && !fifo_empty_i
                 && !buf_full && !rst;
  assign last_done_c = head_valid && m_ready_i && head[DSIZE];

  // State, remaining-word and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (last_done_c) begin
        pkt_count_q <= pkt_count_q + PKT_CNT_W'(1);
      end
    end
  end

  // Next-state logic; a full packet's worth of data wins over flush.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (fifo_counter_i >= CNT_W'(PKT_LEN)) begin
          state_d     = BURST;
          remaining_d = CNT_W'(PKT_LEN);
        end else if (flush_i && !fifo_empty_i && (fifo_counter_i != '0)) begin
          // Zero-count guard keeps an inconsistent FIFO from starting an empty packet.
          state_d     = BURST;
          remaining_d = fifo_counter_i;
        end
      end
      BURST: begin
        if (pop_c) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fifo_skid_buf #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (pop_c),
    .push_data  ({remaining_q == CNT_W'(1), fifo_rd_data_i}),
    .pop        (m_ready_i),
    .head_data  (head),
    .head_valid (head_valid),
    .full       (buf_full)
  );

  assign fifo_rd_en_o = pop_c;
  assign m_data_o     = head[DSIZE-1:0];
  assign m_valid_o    = head_valid;
  assign m_last_o     = head[DSIZE] & head_valid;
  assign pkt_count_o  = pkt_count_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DSIZE, default 32, data word width in bits.
REQ-002 Parameter ASIZE, default 4, FIFO address width; FIFO depth is 2**ASIZE.
REQ-003 Parameter PKT_LEN, default 4, words per full packet; legal range 1..2**ASIZE, elaboration error otherwise.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 fifo_rd_data_i  input  DSIZE  head word of the upstream first-word-fall-through FIFO; valid whenever fifo_empty_i=0.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_counter_i  input  ASIZE+1  upstream FIFO occupancy.
REQ-010 fifo_rd_en_o  output  1  pop strobe to the FIFO; the next head word is visible one cycle later.
REQ-011 flush_i  input  1  request to emit a short packet from the residual FIFO contents.
REQ-012 m_data_o  output  DSIZE  stream data.
REQ-013 m_valid_o  output  1  stream beat valid.
REQ-014 m_last_o  output  1  final beat of a packet; qualified by m_valid_o.
REQ-015 m_ready_i  input  1  downstream accept; a beat transfers when m_valid_o=1 and m_ready_i=1.
REQ-016 pkt_count_o  output  16  count of completed packets; wraps modulo 2**16.
REQ-017 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, BURST, DRAIN.
REQ-019 IDLE->BURST SHALL occur when fifo_counter_i >= PKT_LEN, loading remaining=PKT_LEN; this condition has priority over flush_i.
REQ-020 IDLE->BURST SHALL otherwise occur when flush_i=1 and fifo_empty_i=0, loading remaining=fifo_counter_i.
REQ-021 flush_i SHALL be ignored outside IDLE, and in IDLE when the FIFO is empty.
REQ-022 fifo_rd_en_o SHALL equal (state==BURST) & (remaining!=0) & !fifo_empty_i & (buffer occupancy<2), derived from registered state only with no combinational path from m_ready_i.
REQ-023 Each pop SHALL write fifo_rd_data_i into a 2-entry output buffer on the same edge, decrement remaining, and tag the entry last=1 when remaining was 1.
REQ-024 BURST->DRAIN SHALL occur on the edge where remaining reaches 0; DRAIN->IDLE SHALL occur on the handshake of the beat tagged last.
REQ-025 Latency from a pop to m_valid_o=1 SHALL be one cycle; with m_ready_i held high, one beat per cycle SHALL be sustained.
REQ-026 While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o SHALL remain stable and m_valid_o SHALL NOT deassert.
REQ-027 A simultaneous buffer push and pop SHALL preserve word order and leave occupancy unchanged.
REQ-028 pkt_count_o SHALL increment by one on each handshake with m_last_o=1; 16'hFFFF SHALL wrap to 0.
REQ-029 Words SHALL leave m_data_o in FIFO order, with none dropped or duplicated.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=IDLE, remaining=0, buffer empty, m_valid_o=0, m_last_o=0, fifo_rd_en_o=0, busy_o=0, pkt_count_o=0, and m_data_o=0.
REQ-031 Reset asserted mid-packet SHALL discard buffered words without further pops; the upstream FIFO's contents are not this block's responsibility.

Structure
REQ-032 Package fifo_pkg SHALL hold the DSIZE/ASIZE defaults and the state enum (IDLE, BURST, DRAIN).
REQ-033 The 2-entry output buffer SHALL be a sub-module named fifo_skid_buf, parameterised by DSIZE+1 to carry the last tag.

Verification
REQ-034 Fill the FIFO with 0..7, m_ready_i=1 -> two packets of {0,1,2,3} and {4,5,6,7}, m_last_o on words 3 and 7, pkt_count_o=2, no idle cycles within a packet.
REQ-035 Fill 3 words (0xA,0xB,0xC), no flush -> m_valid_o stays 0; then pulse flush_i -> 3-beat packet with m_last_o on 0xC.
REQ-036 Packet of 0..3 with m_ready_i toggling 1,0,0,1,... -> m_data_o stable during stalls, fifo_rd_en_o never asserted with occupancy 2, order preserved.
REQ-037 Assert rst while occupancy is 2 mid-packet -> next cycle m_valid_o=0, busy_o=0, pkt_count_o=0, fifo_rd_en_o=0.
REQ-038 Complete 65536 one-word flush packets, or force pkt_count_o near wrap -> count wraps 16'hFFFF -> 0.
REQ-039 Run with 16 words present and PKT_LEN=16 -> a single 16-beat packet; fifo_empty_i=1 after the final pop; FSM returns to IDLE.
